rotation_slicer: RTL and testbench

ROTATION_SLICER -- requirements
Module: rotation_slicer

---
 rtl/rotation_slicer.sv | 122 ++++++++++++
 tb/tb_rotation_slicer.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/rotation_slicer.sv
// Splits each hall-sensor revolution into 2^LOG2_SLICES slices whose lengths sum exactly to the measured period.
// All outputs are registered; a capture resolves two cycles after hall_pulse, and the period is sampled one cycle after it.
module rotation_slicer #(
  parameter int LOG2_SLICES = 7,
  parameter int MIN_PERIOD  = 256
) (
  input  logic                   clk,
  input  logic                   nrst,
  input  logic                   hall_pulse,
  input  logic [31:0]            period,
  output logic                   slice_start,
  output logic [LOG2_SLICES-1:0] slice_idx,
  output logic                   locked,
  output logic                   overrun
);

  typedef enum logic [1:0] {IDLE, ARMED, RUN, WAIT} state_t;

  localparam logic [LOG2_SLICES-1:0] LAST = '1;

  state_t                 state, state_nxt;
  logic                   hall_d;
  logic [31:0]            cnt, cnt_nxt;
  logic [31:0]            base, base_nxt;
  logic [31:0]            per, per_nxt;
  logic [LOG2_SLICES-1:0] rem, rem_nxt;
  logic [LOG2_SLICES-1:0] acc, acc_nxt;
  logic [LOG2_SLICES-1:0] idx_nxt;
  logic                   start_nxt, overrun_nxt;
  logic [LOG2_SLICES:0]   sum;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state       <= IDLE;
      hall_d      <= 1'b0;
      cnt         <= '0;
      base        <= '0;
      per         <= '0;
      rem         <= '0;
      acc         <= '0;
      slice_idx   <= '0;
      slice_start <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      state       <= state_nxt;
      // A second pulse while a capture is pending is dropped.
      hall_d      <= hall_pulse & ~hall_d;
      cnt         <= cnt_nxt;
      base        <= base_nxt;
      per         <= per_nxt;
      rem         <= rem_nxt;
      acc         <= acc_nxt;
      slice_idx   <= idx_nxt;
      slice_start <= start_nxt;
      overrun     <= overrun_nxt;
    end
  end

  assign locked = (state == RUN) || (state == WAIT);

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    base_nxt    = base;
    per_nxt     = per;
    rem_nxt     = rem;
    acc_nxt     = acc;
    idx_nxt     = slice_idx;
    start_nxt   = 1'b0;
    overrun_nxt = 1'b0;
    sum         = {1'b0, acc} + {1'b0, rem};

    if (hall_d) begin
      if (period < 32'(MIN_PERIOD)) begin
        state_nxt = IDLE;
        idx_nxt   = '0;
        cnt_nxt   = '0;
      end else if (state == IDLE) begin
        state_nxt = ARMED;
      end else begin
        // Resync: slice 0 always takes the short length since acc starts at 0, leaving acc = rem.
        state_nxt   = RUN;
        start_nxt   = 1'b1;
        overrun_nxt = (state == RUN) && (slice_idx != LAST);
        idx_nxt     = '0;
        per_nxt     = period;
        base_nxt    = period >> LOG2_SLICES;
        rem_nxt     = period[LOG2_SLICES-1:0];
        acc_nxt     = period[LOG2_SLICES-1:0];
        cnt_nxt     = (period >> LOG2_SLICES) - 32'd1;
      end
    end else begin
      case (state)
        RUN: begin
          if (cnt == 32'd0) begin
            if (slice_idx == LAST) begin
              state_nxt = WAIT;
              cnt_nxt   = per - 32'd1;
            end else begin
              start_nxt = 1'b1;
              idx_nxt   = slice_idx + 1'b1;
              acc_nxt   = sum[LOG2_SLICES-1:0];
              cnt_nxt   = sum[LOG2_SLICES] ? base : base - 32'd1;
            end
          end else begin
            cnt_nxt = cnt - 32'd1;
          end
        end
        WAIT: begin
          if (cnt == 32'd0) begin
            state_nxt = IDLE;
            idx_nxt   = '0;
          end else begin
            cnt_nxt = cnt - 32'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rotation_slicer.sv
// Directed checks of rotation_slicer with N=8, MIN_PERIOD=16: arming, fractional slice lengths,
// overrun, WAIT timeout, invalid period and asynchronous reset.
module tb_rotation_slicer;

  localparam int L = 3;
  localparam int N = 8;

  logic        clk = 1'b0;
  logic        nrst;
  logic        hall_pulse;
  logic [31:0] period;
  logic        slice_start;
  logic [L-1:0] slice_idx;
  logic        locked;
  logic        overrun;

  int total = 0;
  int bad   = 0;
  int exp_len [N-1];

  rotation_slicer #(.LOG2_SLICES(L), .MIN_PERIOD(16)) dut (
    .clk        (clk),
    .nrst       (nrst),
    .hall_pulse (hall_pulse),
    .period     (period),
    .slice_start(slice_start),
    .slice_idx  (slice_idx),
    .locked     (locked),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse in cycle C; returns in cycle C+2 where the capture is visible.
  task automatic hall(input logic [31:0] p);
    hall_pulse = 1'b1;
    period     = p;
    tick();
    hall_pulse = 1'b0;
    tick();
  endtask

  // From a slice-0 start, measure slices 0..N-2 up to the start of slice N-1.
  task automatic run_slices(input string tag);
    int n;
    for (int k = 0; k < N-1; k++) begin
      n = 0;
      do begin
        tick();
        n++;
      end while (!slice_start && n < 200);
      chk({tag, "_len"}, n, exp_len[k]);
      chk({tag, "_idx"}, 32'(slice_idx), k + 1);
      chk({tag, "_ovr"}, 32'(overrun), 0);
    end
  endtask

  initial begin
    logic seen;
    nrst       = 1'b0;
    hall_pulse = 1'b0;
    period     = '0;
    #1;
    chk("rst_start", 32'(slice_start), 0);
    chk("rst_idx", 32'(slice_idx), 0);
    chk("rst_locked", 32'(locked), 0);
    chk("rst_overrun", 32'(overrun), 0);
    tick();
    tick();
    nrst = 1'b1;

    // No hall at all: everything stays quiet.
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick();
      seen |= slice_start | locked | overrun | (slice_idx != '0);
    end
    chk("idle_quiet", 32'(seen), 0);

    // Two-cycle hall pulse from IDLE: only one capture, so ARMED without slices.
    hall_pulse = 1'b1;
    period     = 32'd80;
    tick();
    tick();
    hall_pulse = 1'b0;
    chk("arm_start", 32'(slice_start), 0);
    chk("arm_locked", 32'(locked), 0);
    tick();
    chk("arm_second_pulse_ignored", 32'(slice_start), 0);
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      seen |= slice_start | locked;
    end
    chk("armed_quiet", 32'(seen), 0);

    hall(32'd80);
    chk("p80_start", 32'(slice_start), 1);
    chk("p80_idx0", 32'(slice_idx), 0);
    chk("p80_locked", 32'(locked), 1);
    chk("p80_ovr", 32'(overrun), 0);
    exp_len = '{10, 10, 10, 10, 10, 10, 10};
    run_slices("p80");
    for (int i = 0; i < 10; i++) tick();
    chk("wait_idx", 32'(slice_idx), 7);
    chk("wait_start", 32'(slice_start), 0);
    chk("wait_locked", 32'(locked), 1);
    seen = 1'b0;
    for (int i = 0; i < 79; i++) begin
      tick();
      seen |= slice_start;
    end
    chk("wait_no_start", 32'(seen), 0);
    chk("wait_still_locked", 32'(locked), 1);
    chk("wait_idx_held", 32'(slice_idx), 7);
    tick();
    chk("timeout_locked", 32'(locked), 0);
    chk("timeout_idx", 32'(slice_idx), 0);

    // Fractional period 83: slices 2, 5 and 7 are long.
    hall(32'd83);
    tick();
    tick();
    hall(32'd83);
    chk("p83_start", 32'(slice_start), 1);
    chk("p83_locked", 32'(locked), 1);
    exp_len = '{10, 10, 11, 10, 10, 11, 10};
    run_slices("p83");
    // Slice 7 is 11 long; a hall exactly one period after resync lands on its expiry.
    for (int i = 0; i < 9; i++) tick();
    hall(32'd83);
    chk("p83_resync_start", 32'(slice_start), 1);
    chk("p83_resync_idx", 32'(slice_idx), 0);
    chk("p83_resync_ovr", 32'(overrun), 0);

    // Early hall at idx 0 overruns; then lock at 80 and overrun at 50.
    hall(32'd80);
    chk("early_ovr", 32'(overrun), 1);
    chk("early_start", 32'(slice_start), 1);
    for (int i = 0; i < 48; i++) tick();
    hall(32'd50);
    chk("p50_ovr", 32'(overrun), 1);
    chk("p50_start", 32'(slice_start), 1);
    chk("p50_idx", 32'(slice_idx), 0);
    exp_len = '{6, 6, 6, 7, 6, 6, 6};
    run_slices("p50");

    // Period below MIN_PERIOD drops lock.
    hall(32'd12);
    chk("bad_locked", 32'(locked), 0);
    chk("bad_start", 32'(slice_start), 0);
    chk("bad_idx", 32'(slice_idx), 0);

    hall(32'd80);
    tick();
    hall(32'd80);
    chk("relock_start", 32'(slice_start), 1);
    for (int i = 0; i < 15; i++) tick();
    chk("mid_run_idx", 32'(slice_idx), 1);
    nrst = 1'b0;
    #1;
    chk("async_locked", 32'(locked), 0);
    chk("async_idx", 32'(slice_idx), 0);
    chk("async_start", 32'(slice_start), 0);
    chk("async_ovr", 32'(overrun), 0);
    tick();
    nrst = 1'b1;
    tick();
    hall(32'd80);
    chk("post_rst_armed_start", 32'(slice_start), 0);
    chk("post_rst_armed_locked", 32'(locked), 0);
    tick();
    hall(32'd80);
    chk("post_rst_run_start", 32'(slice_start), 1);
    chk("post_rst_run_locked", 32'(locked), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
